// File: rtl/seg_display_scanner.sv
// Four-digit multiplexed seven-segment driver: sequential double-dabble
// binary-to-BCD conversion of a 16-bit value, then active-low digit scan.
module seg_display_scanner #(
   parameter int unsigned REFRESH_DIV   = 50000,
   parameter bit          BLANK_LEADING = 1'b1
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [15:0] value,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        busy,
   output logic        overflow
);

   // state   | meaning
   // S_IDLE  | compare value against last converted src, start on change
   // S_SHIFT | one add-3 adjust plus shift per cycle, 16 cycles
   // S_DONE  | publish BCD digits and overflow flag atomically
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam int unsigned       PRE_W    = $clog2(REFRESH_DIV);
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);

   logic [1:0]       state_q, state_d;
   logic [15:0]      src_q, src_d;
   logic [15:0]      shreg_q, shreg_d;
   logic [19:0]      bcd_q, bcd_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0][3:0]  dig_q, dig_d;
   logic             ovf_q, ovf_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [1:0]       idx_q, idx_d;

   logic [3:0]       cur_dig;
   logic             lead_zero;

   function automatic logic [19:0] dabble_adj(input logic [19:0] b);
      logic [19:0] r;
      r = b;
      for (int n = 0; n < 5; n++) begin
         if (r[4*n +: 4] >= 4'd5) begin
            r[4*n +: 4] = r[4*n +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      shreg_d = shreg_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      dig_d   = dig_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (value != src_q) begin
               src_d   = value;
               shreg_d = value;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            {bcd_d, shreg_d} = {dabble_adj(bcd_q), shreg_q} << 1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            dig_d   = bcd_q[15:0];
            ovf_d   = |bcd_q[19:16];
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pre_d = pre_q;
      idx_d = idx_q;
      if (pre_q == PRE_LAST) begin
         pre_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         pre_d = pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         shreg_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         dig_q   <= '0;
         ovf_q   <= 1'b0;
         pre_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         shreg_q <= shreg_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         ovf_q   <= ovf_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
      end
   end

   // A digit is blanked only when it and every more-significant digit are zero.
   always_comb begin
      cur_dig   = dig_q[idx_q];
      lead_zero = 1'b0;
      case (idx_q)
         2'd1:    lead_zero = (dig_q[3:1] == '0);
         2'd2:    lead_zero = (dig_q[3:2] == '0);
         2'd3:    lead_zero = (dig_q[3] == '0);
         default: lead_zero = 1'b0;
      endcase
   end

   always_comb begin
      if (ovf_q) begin
         seg = 7'b1111110;
      end else if (BLANK_LEADING && lead_zero) begin
         seg = 7'b1111111;
      end else begin
         seg = seg_decode(cur_dig);
      end
   end

   assign an       = ~(4'b0001 << idx_q);
   assign busy     = (state_q != S_IDLE);
   assign overflow = ovf_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner: constant vector table,
// hand-written corner sequences and random values against a decimal model.
module tb_seg_display_scanner;

   localparam int DIV = 4;

   logic        clk;
   logic        n_reset;
   logic [15:0] value;
   logic [6:0]  seg1, seg2;
   logic [3:0]  an1, an2;
   logic        busy1, busy2;
   logic        ovf1, ovf2;

   int n_cmp = 0;
   int n_bad = 0;
   int tcyc  = 0;

   logic [6:0] seg_lut [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};

   typedef struct {
      int             v;
      bit             ovf;
      logic [3:0][6:0] s;   // s[0] = ones digit, blanking enabled
   } vec_t;

   vec_t vecs [8];

   seg_display_scanner #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) u_dut_blank (
      .clk(clk), .n_reset(n_reset), .value(value),
      .seg(seg1), .an(an1), .busy(busy1), .overflow(ovf1)
   );

   seg_display_scanner #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b0)) u_dut_full (
      .clk(clk), .n_reset(n_reset), .value(value),
      .seg(seg2), .an(an2), .busy(busy2), .overflow(ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clock edges since reset release; the scanned digit is (tcyc / DIV) % 4.
   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) tcyc <= 0;
      else          tcyc <= tcyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] exp_seg(input int v, input int ix, input bit blank);
      int p;
      p = 1;
      for (int k = 0; k < ix; k++) p = p * 10;
      if (v > 9999) return 7'b1111110;
      if (blank && ix > 0 && v < p) return 7'b1111111;
      return seg_lut[(v / p) % 10];
   endfunction

   function automatic logic [3:0] exp_an(input int ix);
      logic [3:0] a;
      a = 4'b1111;
      a[ix] = 1'b0;
      return a;
   endfunction

   // Called at a negedge; checks one full frame on both instances.
   task automatic check_frame(input int v, input string tag);
      int ix;
      logic [6:0] e;
      chk({tag, " overflow"}, 32'(ovf1), 32'(v > 9999));
      chk({tag, " overflow_full"}, 32'(ovf2), 32'(v > 9999));
      for (int k = 0; k < 4*DIV; k++) begin
         ix = (tcyc / DIV) % 4;
         chk($sformatf("%s an[%0d]", tag, ix), 32'(an1), 32'(exp_an(ix)));
         chk($sformatf("%s an_full[%0d]", tag, ix), 32'(an2), 32'(exp_an(ix)));
         e = exp_seg(v, ix, 1'b1);
         chk($sformatf("%s seg[%0d]", tag, ix), 32'(seg1), 32'(e));
         e = exp_seg(v, ix, 1'b0);
         chk($sformatf("%s seg_full[%0d]", tag, ix), 32'(seg2), 32'(e));
         @(negedge clk);
      end
   endtask

   // Called at a negedge; returns number of sampled busy-high cycles.
   task automatic run_conv(input int v, output int n);
      value = v[15:0];
      @(negedge clk);
      n = 0;
      while (busy1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n, n2, ix, last, v;
      logic [6:0] e;

      vecs[0] = '{v:1234,  ovf:1'b0, s:{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
      vecs[1] = '{v:7,     ovf:1'b0, s:{7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}};
      vecs[2] = '{v:100,   ovf:1'b0, s:{7'b1111111, 7'b1001111, 7'b0000001, 7'b0000001}};
      vecs[3] = '{v:9999,  ovf:1'b0, s:{7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100}};
      vecs[4] = '{v:10000, ovf:1'b1, s:{7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
      vecs[5] = '{v:65535, ovf:1'b1, s:{7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
      vecs[6] = '{v:1000,  ovf:1'b0, s:{7'b1001111, 7'b0000001, 7'b0000001, 7'b0000001}};
      vecs[7] = '{v:0,     ovf:1'b0, s:{7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};

      // Reset with value=0: reset outputs, and no conversion afterwards.
      n_reset = 1'b0;
      value   = 16'd0;
      repeat (3) @(negedge clk);
      chk("reset seg", 32'(seg1), 32'(7'b0000001));
      chk("reset an", 32'(an1), 32'(4'b1110));
      chk("reset busy", 32'(busy1), 32'(1'b0));
      chk("reset overflow", 32'(ovf1), 32'(1'b0));
      n_reset = 1'b1;
      @(negedge clk);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (busy1 || busy2) n++;
         @(negedge clk);
      end
      chk("idle busy after reset", 32'(n), 32'(0));
      check_frame(0, "post-reset");

      // Vector table: conversion latency, overflow and every digit.
      for (int i = 0; i < 8; i++) begin
         run_conv(vecs[i].v, n);
         chk($sformatf("busy cycles v=%0d", vecs[i].v), 32'(n), 32'(17));
         chk($sformatf("overflow v=%0d", vecs[i].v), 32'(ovf1), 32'(vecs[i].ovf));
         for (int k = 0; k < 4*DIV; k++) begin
            ix = (tcyc / DIV) % 4;
            e  = vecs[i].s[ix];
            chk($sformatf("table v=%0d seg[%0d]", vecs[i].v, ix), 32'(seg1), 32'(e));
            e  = exp_seg(vecs[i].v, ix, 1'b0);
            chk($sformatf("table v=%0d seg_full[%0d]", vecs[i].v, ix), 32'(seg2), 32'(e));
            @(negedge clk);
         end
      end

      // Value changes on the 5th busy cycle: 1234 shown, then 5678 re-converted.
      value = 16'd1234;
      @(negedge clk);
      n = 0;
      while (busy1 && n < 100) begin
         n++;
         if (n == 5) value = 16'd5678;
         @(negedge clk);
      end
      chk("change first busy cycles", 32'(n), 32'(17));
      ix = (tcyc / DIV) % 4;
      e  = exp_seg(1234, ix, 1'b1);
      chk("change first display", 32'(seg1), 32'(e));
      chk("change idle gap", 32'(busy1), 32'(1'b0));
      @(negedge clk);
      n2 = 0;
      while (busy1 && n2 < 100) begin
         n2++;
         @(negedge clk);
      end
      chk("change second busy cycles", 32'(n2), 32'(17));
      check_frame(5678, "change second");

      // Reset pulse during SHIFT with value=42 held.
      value = 16'd42;
      repeat (6) @(negedge clk);
      chk("midreset busy before", 32'(busy1), 32'(1'b1));
      #2 n_reset = 1'b0;
      #1;
      chk("midreset seg", 32'(seg1), 32'(7'b0000001));
      chk("midreset an", 32'(an1), 32'(4'b1110));
      chk("midreset busy", 32'(busy1), 32'(1'b0));
      chk("midreset overflow", 32'(ovf1), 32'(1'b0));
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
      n = 0;
      while (busy1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("midreset busy cycles", 32'(n), 32'(17));
      check_frame(42, "midreset 42");

      // Random values, biased toward short numbers to exercise blanking.
      last = 42;
      for (int r = 0; r < 16; r++) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom_range(0, 9);
            1:       v = $urandom_range(10, 999);
            2:       v = $urandom_range(1000, 9999);
            default: v = $urandom_range(0, 65535);
         endcase
         if (v == last) v = v ^ 1;
         run_conv(v, n);
         chk($sformatf("rand busy cycles v=%0d", v), 32'(n), 32'(17));
         check_frame(v, $sformatf("rand v=%0d", v));
         last = v;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
